// File: rtl/simplez_pkg.sv
// simplez_pkg: opcode, sequencer state, ALU function and instruction-class encodings
// shared by the Simplez control unit and datapath.  Rev 1.0
`default_nettype none

package simplez_pkg;

  localparam logic [2:0] OP_ST   = 3'd0;
  localparam logic [2:0] OP_LD   = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_BR   = 3'd3;
  localparam logic [2:0] OP_BZ   = 3'd4;
  localparam logic [2:0] OP_CLR  = 3'd5;
  localparam logic [2:0] OP_DEC  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_DEC  = 2'b10;
  localparam logic [1:0] ALU_CLR  = 2'b11;

  typedef enum logic [2:0] {
    S_I0   = 3'd0,
    S_I1   = 3'd1,
    S_DEC  = 3'd2,
    S_O0   = 3'd3,
    S_O1   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    IC_MEM    = 3'd0,
    IC_JUMP   = 3'd1,
    IC_NOJUMP = 3'd2,
    IC_ALU    = 3'd3,
    IC_HALT   = 3'd4
  } iclass_e;

  // Memory-operand instructions that read the operand (LD, ADD) rather than write it (ST).
  function automatic logic is_mem_read(input logic [2:0] op);
    return (op == OP_LD) || (op == OP_ADD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/simplez_ctrl_decode.sv
// simplez_ctrl_decode: combinational opcode/z decode into an instruction class
// and the ALU function the instruction uses.  Rev 1.0
`default_nettype none

module simplez_ctrl_decode
  import simplez_pkg::*;
(
  input  logic [2:0] opcode,
  input  logic       z,
  output iclass_e    iclass,
  output logic [1:0] alu_op
);

  always_comb begin
    iclass = IC_HALT;
    alu_op = ALU_PASS;
    case (opcode)
      OP_ST:   iclass = IC_MEM;
      OP_LD:   iclass = IC_MEM;
      OP_ADD: begin
        iclass = IC_MEM;
        alu_op = ALU_ADD;
      end
      OP_BR:   iclass = IC_JUMP;
      OP_BZ:   iclass = z ? IC_JUMP : IC_NOJUMP;
      OP_CLR: begin
        iclass = IC_ALU;
        alu_op = ALU_CLR;
      end
      OP_DEC: begin
        iclass = IC_ALU;
        alu_op = ALU_DEC;
      end
      default: iclass = IC_HALT;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/simplez_ctrl.sv
// simplez_ctrl: Simplez fetch/decode/operand sequencer driving all datapath
// microorders; state advances on the falling clock edge.  Rev 1.0
`default_nettype none

module simplez_ctrl
  import simplez_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [2:0] opcode,
  input  logic       z,
  output logic       lec,
  output logic       esc,
  output logic       eri,
  output logic       era,
  output logic       sel_ra,
  output logic       incp,
  output logic       ecp,
  output logic       eac,
  output logic [1:0] alu_op,
  output logic       halted,
  output logic [2:0] state
);

  state_e     r_state;
  iclass_e    w_iclass;
  logic [1:0] w_dec_alu;

  simplez_ctrl_decode u_decode (
    .opcode (opcode),
    .z      (z),
    .iclass (w_iclass),
    .alu_op (w_dec_alu)
  );

  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_I0;
    end else begin
      case (r_state)
        S_I0:  r_state <= S_I1;
        S_I1:  r_state <= S_DEC;
        S_DEC: begin
          case (w_iclass)
            IC_MEM:  r_state <= S_O0;
            IC_HALT: r_state <= S_HALT;
            default: r_state <= S_I0;
          endcase
        end
        S_O0:   r_state <= S_O1;
        S_O1:   r_state <= S_I0;
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_I0;
      endcase
    end
  end

  // Microorders depend on the opcode/z seen during the current state (RI is only
  // loaded at the end of I1), so they are decoded from the state register rather
  // than registered ahead; rstn gates them so no write can fire during reset.
  always_comb begin
    lec    = 1'b0;
    esc    = 1'b0;
    eri    = 1'b0;
    era    = 1'b0;
    sel_ra = 1'b0;
    incp   = 1'b0;
    ecp    = 1'b0;
    eac    = 1'b0;
    alu_op = ALU_PASS;
    halted = 1'b0;
    if (rstn) begin
      case (r_state)
        S_I0: lec = 1'b1;
        S_I1: begin
          eri  = 1'b1;
          incp = 1'b1;
        end
        S_DEC: begin
          case (w_iclass)
            IC_MEM: begin
              era    = 1'b1;
              sel_ra = 1'b1;
            end
            IC_JUMP: begin
              ecp    = 1'b1;
              era    = 1'b1;
              sel_ra = 1'b1;
            end
            IC_NOJUMP: era = 1'b1;
            IC_ALU: begin
              eac    = 1'b1;
              alu_op = w_dec_alu;
              era    = 1'b1;
            end
            default: ;
          endcase
        end
        S_O0: begin
          lec = is_mem_read(opcode);
          esc = (opcode == OP_ST);
        end
        S_O1: begin
          era = 1'b1;
          if (is_mem_read(opcode)) begin
            eac    = 1'b1;
            alu_op = w_dec_alu;
          end
        end
        S_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_simplez_ctrl.sv
// tb_simplez_ctrl: table-driven per-cycle check of state and microorders, plus
// hand-written reset-abort and HALT sequences.
`timescale 1ns/1ps
`default_nettype none

module tb_simplez_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic [2:0] opcode;
  logic       z;
  logic       lec, esc, eri, era, sel_ra, incp, ecp, eac, halted;
  logic [1:0] alu_op;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  simplez_ctrl dut (
    .clk    (clk),
    .rstn   (rstn),
    .opcode (opcode),
    .z      (z),
    .lec    (lec),
    .esc    (esc),
    .eri    (eri),
    .era    (era),
    .sel_ra (sel_ra),
    .incp   (incp),
    .ecp    (ecp),
    .eac    (eac),
    .alu_op (alu_op),
    .halted (halted),
    .state  (state)
  );

  always #5 clk = ~clk;

  // Output bundle: {lec,esc,eri,era,sel_ra,incp,ecp,eac,alu_op[1:0],halted}
  function automatic logic [10:0] o(input logic l, input logic e, input logic ri,
                                    input logic ra, input logic s, input logic ip,
                                    input logic cp, input logic ac, input logic [1:0] al,
                                    input logic h);
    return {l, e, ri, ra, s, ip, cp, ac, al, h};
  endfunction

  function automatic logic [10:0] outs();
    return {lec, esc, eri, era, sel_ra, incp, ecp, eac, alu_op, halted};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic        zf;
    logic [2:0]  st;
    logic [10:0] ou;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [2:0] op, input logic zf, input logic [2:0] st,
                     input logic [10:0] ou);
    vec_t v;
    v.op = op; v.zf = zf; v.st = st; v.ou = ou;
    vecs.push_back(v);
  endtask

  // Standard fetch rows (I0, I1) for a given opcode.
  task automatic add_fetch(input logic [2:0] op, input logic zf);
    add(op, zf, 3'd0, o(1,0,0,0,0,0,0,0,2'b00,0));
    add(op, zf, 3'd1, o(0,0,1,0,0,1,0,0,2'b00,0));
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  int incp_cnt;
  logic [2:0] halt_seq [6];

  initial begin
    rstn = 1'b0; opcode = 3'd0; z = 1'b0;

    // LD: 5 cycles
    add_fetch(3'd1, 0);
    add(3'd1, 0, 3'd2, o(0,0,0,1,1,0,0,0,2'b00,0));
    add(3'd1, 0, 3'd3, o(1,0,0,0,0,0,0,0,2'b00,0));
    add(3'd1, 0, 3'd4, o(0,0,0,1,0,0,0,1,2'b00,0));
    // ST: esc only in O0, no AC load
    add_fetch(3'd0, 0);
    add(3'd0, 0, 3'd2, o(0,0,0,1,1,0,0,0,2'b00,0));
    add(3'd0, 0, 3'd3, o(0,1,0,0,0,0,0,0,2'b00,0));
    add(3'd0, 0, 3'd4, o(0,0,0,1,0,0,0,0,2'b00,0));
    // ADD
    add_fetch(3'd2, 1);
    add(3'd2, 1, 3'd2, o(0,0,0,1,1,0,0,0,2'b00,0));
    add(3'd2, 1, 3'd3, o(1,0,0,0,0,0,0,0,2'b00,0));
    add(3'd2, 1, 3'd4, o(0,0,0,1,0,0,0,1,2'b01,0));
    // BR
    add_fetch(3'd3, 0);
    add(3'd3, 0, 3'd2, o(0,0,0,1,1,0,1,0,2'b00,0));
    // BZ taken
    add_fetch(3'd4, 1);
    add(3'd4, 1, 3'd2, o(0,0,0,1,1,0,1,0,2'b00,0));
    // BZ not taken
    add_fetch(3'd4, 0);
    add(3'd4, 0, 3'd2, o(0,0,0,1,0,0,0,0,2'b00,0));
    // DEC then CLR
    add_fetch(3'd6, 0);
    add(3'd6, 0, 3'd2, o(0,0,0,1,0,0,0,1,2'b10,0));
    add_fetch(3'd5, 1);
    add(3'd5, 1, 3'd2, o(0,0,0,1,0,0,0,1,2'b11,0));
    // HALT, then stays
    add_fetch(3'd7, 0);
    add(3'd7, 0, 3'd2, o(0,0,0,0,0,0,0,0,2'b00,0));
    add(3'd0, 0, 3'd5, o(0,0,0,0,0,0,0,0,2'b00,1));
    add(3'd1, 1, 3'd5, o(0,0,0,0,0,0,0,0,2'b00,1));

    // Reset state: outputs gated off even though state is I0
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {29'd0, state}, 32'd0);
    chk("reset_outs", {21'd0, outs()}, 32'd0);

    step();
    rstn = 1'b1;
    foreach (vecs[i]) begin
      opcode = vecs[i].op;
      z      = vecs[i].zf;
      @(posedge clk);
      chk($sformatf("vec%0d_state", i), {29'd0, state}, {29'd0, vecs[i].st});
      chk($sformatf("vec%0d_outs", i), {21'd0, outs()}, {21'd0, vecs[i].ou});
      step();
    end

    // Reset during O0 of ST: esc must drop and state return to I0 asynchronously
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    opcode = 3'd0; z = 1'b0;
    step(); step(); step();
    @(posedge clk);
    chk("abort_pre_state", {29'd0, state}, 32'd3);
    chk("abort_pre_esc", {31'd0, esc}, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("abort_esc", {31'd0, esc}, 32'd0);
    chk("abort_state", {29'd0, state}, 32'd0);
    chk("abort_outs", {21'd0, outs()}, 32'd0);
    step();
    rstn = 1'b1;
    opcode = 3'd1;
    @(posedge clk);
    chk("refetch_i0", {18'd0, state, outs()}, {18'd0, 3'd0, o(1,0,0,0,0,0,0,0,2'b00,0)});
    step();
    @(posedge clk);
    chk("refetch_i1", {18'd0, state, outs()}, {18'd0, 3'd1, o(0,0,1,0,0,1,0,0,2'b00,0)});

    // HALT straight out of reset: 0,1,2,5,5,5 with a single incp
    step();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    opcode = 3'd7;
    incp_cnt = 0;
    halt_seq[0] = 3'd0; halt_seq[1] = 3'd1; halt_seq[2] = 3'd2;
    halt_seq[3] = 3'd5; halt_seq[4] = 3'd5; halt_seq[5] = 3'd5;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      chk($sformatf("halt_c%0d_state", c), {29'd0, state}, {29'd0, halt_seq[c]});
      chk($sformatf("halt_c%0d_halted", c), {31'd0, halted}, {31'd0, (c >= 3)});
      chk($sformatf("halt_c%0d_excl", c), {30'd0, lec & esc, incp & ecp}, 32'd0);
      if (incp) incp_cnt++;
      step();
    end
    chk("halt_incp_count", incp_cnt, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/simplez_ctrl.md
# simplez_ctrl

Control unit (sequencer) for the Simplez CPU core. It reads the 3-bit opcode from the instruction register and the accumulator zero flag, and drives every datapath microorder: memory read/write, register enables, RA source select, CP update and accumulator ALU function. It sits beside the datapath (RA, CP, RI, AC, memory) and replaces the fixed two-state fetch sequencer with the full fetch/decode/operand cycle.

## Interface
- No parameters. Opcode, state and ALU encodings come from the shared package.
- clk  in  1  system clock; all state updates on the falling edge, matching the datapath.
- rstn  in  1  asynchronous, active-low reset.
- opcode  in  3  RI[11:9]; valid from state DEC onward.
- z  in  1  1 when AC == 0.
- lec  out  1  memory read; data is valid on busD one cycle later.
- esc  out  1  memory write of AC to address RA.
- eri  out  1  load RI from busD.
- era  out  1  load RA.
- sel_ra  out  1  RA source: 0 = CP, 1 = RI[8:0].
- incp  out  1  CP <= CP + 1.
- ecp  out  1  CP <= RI[8:0].
- eac  out  1  load AC from ALU.
- alu_op  out  2  ALU function: 00 = PASS busD, 01 = ADD AC+busD, 10 = DEC AC-1, 11 = CLR.
- halted  out  1  1 while in state HALT.
- state  out  3  current state, for debug LEDs.

## Operation
- Opcodes: ST=0, LD=1, ADD=2, BR=3, BZ=4, CLR=5, DEC=6, HALT=7.
- Invariant: on entry to I0, RA equals CP.
- States and microorders; any output not listed is 0:
  - I0: lec. Next state I1.
  - I1: eri, incp. Next state DEC.
  - DEC, for ST, LD and ADD: era, sel_ra=1. Next state O0.
  - DEC, for BR, and for BZ with z=1: ecp, era, sel_ra=1. Next state I0.
  - DEC, for BZ with z=0: era, sel_ra=0. Next state I0.
  - DEC, for CLR: eac, alu_op=11, era, sel_ra=0. Next state I0.
  - DEC, for DEC: eac, alu_op=10, era, sel_ra=0. Next state I0.
  - DEC, for HALT: no microorders. Next state HALT.
  - O0: lec for LD and ADD; esc for ST. Next state O1.
  - O1, for LD: eac, alu_op=00. For ADD: eac, alu_op=01. For ST: no AC load. In all three: era, sel_ra=0. Next state I0.
  - HALT: all microorders 0, halted=1. Stays here until reset.
- Opcode is sampled combinationally in DEC, O0 and O1; RI does not change outside I1.
- z is sampled only in DEC.
- The ALU arithmetic and its 12-bit wrap-around belong to the datapath; this block only selects alu_op.

## Timing
- rstn low: state goes to I0 asynchronously, and every output is forced to 0 while rstn is low.
- After rstn rises, the first falling edge executes I0.
- Reset in the middle of an instruction aborts it; no partial write survives, because esc is gated by rstn.
- Instruction length:
  - ST, LD, ADD: 5 cycles.
  - BR, BZ, CLR, DEC: 3 cycles.
  - HALT: enters HALT 3 cycles after its I0.
- At most one of lec and esc is high in any cycle.
- At most one of incp and ecp is high in any cycle.
- state encoding: I0=0, I1=1, DEC=2, O0=3, O1=4, HALT=5. Codes 6 and 7 go to I0.

## Structure
- Package simplez_pkg holds the opcode constants, the state encodings and the alu_op encodings.
- One sub-module, simplez_ctrl_decode (combinational): maps opcode and z to an instruction class (MEM, JUMP, NOJUMP, ALU, HALT) plus its alu_op.
- The FSM and output logic stay in simplez_ctrl.

## Test plan
- Reset then release, opcode=7 (HALT): state sequence 0,1,2,5,5…; halted=1 from cycle 4; incp high exactly once.
- opcode=1 (LD): lec in I0; eri+incp in I1; era+sel_ra=1 in DEC; lec in O0; eac+alu_op=00+era+sel_ra=0 in O1; back to I0 after 5 cycles.
- opcode=0 (ST): esc=1 only in O0; eac never high; lec high only in I0.
- opcode=4 (BZ) with z=1: ecp=1 and sel_ra=1 in DEC. Repeat with z=0: ecp=0 and sel_ra=0. Both cases return to I0 after 3 cycles.
- opcode=6 (DEC) then opcode=5 (CLR): DEC cycle shows eac=1 with alu_op=10, then eac=1 with alu_op=11.
- Assert rstn low during O0 of ST: esc drops immediately, state=0 asynchronously, and the next fetch starts cleanly after release.
